// File: rtl/axis_pattern_gen.sv
// AXI4-Stream video test-pattern source: H_ACTIVE x V_ACTIVE frames, one pixel per beat,
// SOF on tuser, end-of-line on tlast, with a frame-done pulse and wrapping frame counter.
module axis_pattern_gen #(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int H_ACTIVE             = 640,
  parameter int V_ACTIVE             = 480,
  parameter int FCNT_WIDTH           = 16
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic                            enable,
  input  logic [1:0]                      pattern,
  output logic                            m_axis_tvalid,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                            m_axis_tlast,
  output logic                            m_axis_tuser,
  input  logic                            m_axis_tready,
  output logic                            frame_done,
  output logic [FCNT_WIDTH-1:0]           frame_count
);

  localparam int W  = C_M_AXIS_TDATA_WIDTH;
  localparam int HW = W / 2;
  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_q, state_d;
  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic [1:0]            pat_q, pat_d;
  logic [W-1:0]          ramp_q, ramp_d;
  logic                  tvalid_q, tvalid_d;
  logic [W-1:0]          tdata_q, tdata_d;
  logic                  tlast_q, tlast_d;
  logic                  tuser_q, tuser_d;
  logic                  done_q, done_d;
  logic [FCNT_WIDTH-1:0] fcnt_q, fcnt_d;

  logic [XW-1:0]         x_inc;
  logic [YW-1:0]         y_inc;
  logic [FCNT_WIDTH-1:0] fcnt_inc;
  logic                  last_beat;
  logic                  start;
  logic [FCNT_WIDTH-1:0] start_fid;

  function automatic logic [W-1:0] pixel(input logic [1:0] pat, input logic [XW-1:0] x,
                                         input logic [YW-1:0] y, input logic [W-1:0] ramp,
                                         input logic [FCNT_WIDTH-1:0] fid);
    logic cb;
    cb = (((x >> 3) & XW'(1)) != '0) ^ (((y >> 3) & YW'(1)) != '0);
    case (pat)
      2'd0:    pixel = {HW'(y), HW'(x)};
      2'd1:    pixel = ramp;
      2'd2:    pixel = {W{cb}};
      default: pixel = W'(fid);
    endcase
  endfunction

  always_comb begin
    x_inc     = (x_q == X_LAST) ? '0 : x_q + XW'(1);
    y_inc     = (x_q != X_LAST) ? y_q : ((y_q == Y_LAST) ? '0 : y_q + YW'(1));
    fcnt_inc  = fcnt_q + FCNT_WIDTH'(1);
    last_beat = (x_q == X_LAST) && (y_q == Y_LAST);
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    pat_d     = pat_q;
    ramp_d    = ramp_q;
    tvalid_d  = tvalid_q;
    tdata_d   = tdata_q;
    tlast_d   = tlast_q;
    tuser_d   = tuser_q;
    done_d    = 1'b0;
    fcnt_d    = fcnt_q;
    start     = 1'b0;
    start_fid = fcnt_q;

    unique case (state_q)
      IDLE: begin
        start = enable;
      end
      RUN: begin
        if (m_axis_tready) begin
          if (last_beat) begin
            fcnt_d = fcnt_inc;
            done_d = 1'b1;
            if (enable) begin
              start     = 1'b1;
              start_fid = fcnt_inc;
            end else begin
              state_d  = IDLE;
              x_d      = '0;
              y_d      = '0;
              tvalid_d = 1'b0;
              tdata_d  = '0;
              tlast_d  = 1'b0;
              tuser_d  = 1'b0;
            end
          end else begin
            x_d     = x_inc;
            y_d     = y_inc;
            ramp_d  = ramp_q + W'(1);
            tdata_d = pixel(pat_q, x_inc, y_inc, ramp_q + W'(1), fcnt_q);
            tlast_d = (x_inc == X_LAST);
            tuser_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Frame start is shared by leaving IDLE and back-to-back continuation.
    if (start) begin
      state_d  = RUN;
      x_d      = '0;
      y_d      = '0;
      pat_d    = pattern;
      ramp_d   = '0;
      tvalid_d = 1'b1;
      tuser_d  = 1'b1;
      tlast_d  = 1'b0;
      tdata_d  = pixel(pattern, '0, '0, '0, start_fid);
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      pat_q    <= '0;
      ramp_q   <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
      done_q   <= 1'b0;
      fcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      pat_q    <= pat_d;
      ramp_q   <= ramp_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      tuser_q  <= tuser_d;
      done_q   <= done_d;
      fcnt_q   <= fcnt_d;
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign frame_done    = done_q;
  assign frame_count   = fcnt_q;

endmodule

// File: tb/tb_axis_pattern_gen.sv
// Directed bench for axis_pattern_gen with a 4x3 frame and 32-bit pixels.
module tb_axis_pattern_gen;

  localparam int W = 32;
  localparam int H = 4;
  localparam int V = 3;
  localparam int FW = 16;
  localparam int BEATS = H * V;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          enable = 1'b0;
  logic [1:0]    pattern = 2'd0;
  logic          tready = 1'b0;
  logic          tvalid;
  logic [W-1:0]  tdata;
  logic          tlast;
  logic          tuser;
  logic          frame_done;
  logic [FW-1:0] frame_count;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  axis_pattern_gen #(
    .C_M_AXIS_TDATA_WIDTH(W),
    .H_ACTIVE(H),
    .V_ACTIVE(V),
    .FCNT_WIDTH(FW)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .enable(enable),
    .pattern(pattern),
    .m_axis_tvalid(tvalid),
    .m_axis_tdata(tdata),
    .m_axis_tlast(tlast),
    .m_axis_tuser(tuser),
    .m_axis_tready(tready),
    .frame_done(frame_done),
    .frame_count(frame_count)
  );

  // Expected pixel for beat index within a frame.
  function automatic logic [31:0] exp_pix(input int pat, input int beat, input int fid);
    int x;
    int y;
    x = beat % H;
    y = (beat % BEATS) / H;
    case (pat)
      0:       return {y[15:0], x[15:0]};
      1:       return 32'(beat % BEATS);
      2:       return ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 32'hFFFF_FFFF : 32'h0;
      default: return 32'(fid);
    endcase
  endfunction

  task automatic test_reset();
    areset = 1'b1;
    enable = 1'b0;
    tready = 1'b0;
    repeat (2) @(negedge aclk);
    checks++;
    if ({tvalid, tlast, tuser, frame_done, tdata, frame_count} !== '0) begin
      errors++;
      $display("FAIL reset_values got v=%0b l=%0b u=%0b fd=%0b d=%h fc=%0d want all 0",
               tvalid, tlast, tuser, frame_done, tdata, frame_count);
    end
    areset = 1'b0;
    @(negedge aclk);
  endtask

  task automatic test_basic();
    pattern = 2'd0;
    tready  = 1'b1;
    enable  = 1'b1;
    for (int b = 0; b < BEATS; b++) begin
      @(negedge aclk);
      checks++;
      if (tvalid !== 1'b1 || tdata !== exp_pix(0, b, 0)) begin
        errors++;
        $display("FAIL basic_data beat %0d got v=%0b d=%h want v=1 d=%h", b, tvalid, tdata, exp_pix(0, b, 0));
      end
      checks++;
      if ({tuser, tlast} !== {b == 0, b % H == H - 1}) begin
        errors++;
        $display("FAIL basic_sideband beat %0d got u=%0b l=%0b want u=%0b l=%0b", b, tuser, tlast, b == 0, b % H == H - 1);
      end
      checks++;
      if (frame_done !== 1'b0) begin
        errors++;
        $display("FAIL basic_early_done beat %0d got %0b want 0", b, frame_done);
      end
      if (b == BEATS - 1) enable = 1'b0;
    end
    @(negedge aclk);
    checks++;
    if ({tvalid, frame_done, frame_count} !== {1'b0, 1'b1, 16'd1}) begin
      errors++;
      $display("FAIL basic_end got v=%0b fd=%0b fc=%0d want v=0 fd=1 fc=1", tvalid, frame_done, frame_count);
    end
    @(negedge aclk);
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_width got %0b want 0", frame_done);
    end
  endtask

  task automatic test_backpressure();
    int beat;
    int cyc;
    beat    = 0;
    cyc     = 0;
    pattern = 2'd1;
    enable  = 1'b1;
    while (beat < BEATS && cyc < 100) begin
      @(negedge aclk);
      tready = (cyc % 4 == 0) || (cyc % 4 == 3);
      cyc++;
      checks++;
      if (tvalid !== 1'b1 || tdata !== exp_pix(1, beat, 0) || tuser !== (beat == 0) || tlast !== (beat % H == H - 1)) begin
        errors++;
        $display("FAIL bp_beat cyc %0d got v=%0b d=%h u=%0b l=%0b want v=1 d=%h u=%0b l=%0b", cyc, tvalid, tdata,
                 tuser, tlast, exp_pix(1, beat, 0), beat == 0, beat % H == H - 1);
      end
      if (tready) begin
        if (beat == BEATS - 1) enable = 1'b0;
        beat++;
      end
    end
    checks++;
    if (beat != BEATS) begin
      errors++;
      $display("FAIL bp_timeout got %0d beats want %0d", beat, BEATS);
    end
    @(negedge aclk);
    tready = 1'b1;
    checks++;
    if ({tvalid, frame_done, frame_count} !== {1'b0, 1'b1, 16'd2}) begin
      errors++;
      $display("FAIL bp_end got v=%0b fd=%0b fc=%0d want v=0 fd=1 fc=2", tvalid, frame_done, frame_count);
    end
  endtask

  task automatic test_back_to_back();
    areset = 1'b1;
    @(negedge aclk);
    areset  = 1'b0;
    pattern = 2'd3;
    tready  = 1'b1;
    enable  = 1'b1;
    for (int b = 0; b < 2 * BEATS; b++) begin
      @(negedge aclk);
      checks++;
      if (tvalid !== 1'b1 || tdata !== exp_pix(3, b, b / BEATS)) begin
        errors++;
        $display("FAIL b2b_data beat %0d got v=%0b d=%h want v=1 d=%h", b, tvalid, tdata, exp_pix(3, b, b / BEATS));
      end
      checks++;
      if ({tuser, tlast, frame_done} !== {b % BEATS == 0, b % H == H - 1, b == BEATS}) begin
        errors++;
        $display("FAIL b2b_side beat %0d got u=%0b l=%0b fd=%0b want u=%0b l=%0b fd=%0b", b, tuser, tlast, frame_done,
                 b % BEATS == 0, b % H == H - 1, b == BEATS);
      end
      if (b == BEATS + 3) enable = 1'b0;
    end
    @(negedge aclk);
    checks++;
    if ({tvalid, frame_done, frame_count} !== {1'b0, 1'b1, 16'd2}) begin
      errors++;
      $display("FAIL b2b_end got v=%0b fd=%0b fc=%0d want v=0 fd=1 fc=2", tvalid, frame_done, frame_count);
    end
  endtask

  task automatic test_latching();
    areset = 1'b1;
    @(negedge aclk);
    areset  = 1'b0;
    pattern = 2'd2;
    tready  = 1'b1;
    enable  = 1'b1;
    for (int b = 0; b < 2 * BEATS; b++) begin
      @(negedge aclk);
      checks++;
      if (tvalid !== 1'b1 || tdata !== ((b < BEATS) ? exp_pix(2, b, 0) : exp_pix(0, b, 0))) begin
        errors++;
        $display("FAIL latch_data beat %0d got v=%0b d=%h want v=1 d=%h", b, tvalid, tdata,
                 (b < BEATS) ? exp_pix(2, b, 0) : exp_pix(0, b, 0));
      end
      if (b == 5) pattern = 2'd0;
      if (b == BEATS + 8) enable = 1'b0;
    end
    @(negedge aclk);
    checks++;
    if ({tvalid, frame_count} !== {1'b0, 16'd2}) begin
      errors++;
      $display("FAIL latch_end got v=%0b fc=%0d want v=0 fc=2", tvalid, frame_count);
    end
  endtask

  task automatic test_reset_mid();
    areset = 1'b1;
    @(negedge aclk);
    areset  = 1'b0;
    pattern = 2'd0;
    tready  = 1'b1;
    enable  = 1'b1;
    for (int b = 0; b <= 6; b++) begin
      @(negedge aclk);
      checks++;
      if (tvalid !== 1'b1 || tdata !== exp_pix(0, b, 0)) begin
        errors++;
        $display("FAIL rstmid_pre beat %0d got v=%0b d=%h want v=1 d=%h", b, tvalid, tdata, exp_pix(0, b, 0));
      end
    end
    areset = 1'b1;
    #1;
    checks++;
    if ({tvalid, tlast, tuser, frame_done, tdata, frame_count} !== '0) begin
      errors++;
      $display("FAIL rstmid_async got v=%0b l=%0b u=%0b fd=%0b d=%h fc=%0d want all 0",
               tvalid, tlast, tuser, frame_done, tdata, frame_count);
    end
    @(negedge aclk);
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_done got %0b want 0", frame_done);
    end
    areset = 1'b0;
    @(negedge aclk);
    checks++;
    if ({tvalid, tuser, tlast, frame_done, tdata, frame_count} !== {1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 16'd0}) begin
      errors++;
      $display("FAIL rstmid_restart got v=%0b u=%0b l=%0b fd=%0b d=%h fc=%0d want v=1 u=1 l=0 fd=0 d=0 fc=0",
               tvalid, tuser, tlast, frame_done, tdata, frame_count);
    end
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_latching();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
